pe_ws_dbuf: RTL and testbench

Next-generation weight-stationary MAC processing element for the systolic array. Adds parametrised data and accumulator widths, a signed or unsigned mode, and saturating accumulation. A double-buffered weight register is loaded through a vertical shift chain while the active weight keeps computing. Valid now propagates with the data. Tiled in an R x C grid: activations flow right, partial sums and weights flow down.

---
 rtl/pe_ws_dbuf_pkg.sv | 34 +++
 rtl/pe_ws_dbuf_weight_buf.sv | 35 +++
 rtl/pe_ws_dbuf.sv | 94 +++++++++
 tb/tb_pe_ws_dbuf.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ws_dbuf_pkg.sv
// Shared definitions for the weight-stationary MAC processing element:
// default widths, the extended-sum carrier type and saturation bounds.
package pe_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;
   localparam int unsigned DEFAULT_ACC_W  = 24;

   // Widest accumulator the bounds helper can describe (ACC_W+1 bits must fit).
   localparam int unsigned MAX_ACC_W = 63;

   // Carrier for the ACC_W+1 extended sum; users slice [ACC_W:0].
   typedef logic [MAX_ACC_W:0] acc_ext_t;

   typedef struct packed {
      acc_ext_t lo;
      acc_ext_t hi;
   } sat_bounds_t;

   // Clamp limits in two's complement, valid when sliced to ACC_W+1 bits.
   function automatic sat_bounds_t sat_bounds(input int unsigned acc_w, input logic signed_mode);
      sat_bounds_t b;
      acc_ext_t    one;
      one = acc_ext_t'(1);
      if (signed_mode) begin
         b.hi = (one << (acc_w - 1)) - one;
         b.lo = ~b.hi;
      end else begin
         b.hi = (one << acc_w) - one;
         b.lo = '0;
      end
      return b;
   endfunction

endpackage

// File: rtl/pe_ws_dbuf_weight_buf.sv
// Double-buffered weight store: shadow register on the column shift
// chain, active register feeding the multiplier, and the swap skew stage.
module pe_weight_buf
   import pe_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              w_shift_in,
   input  logic [DATA_W-1:0] w_in,
   input  logic              swap_in,
   output logic [DATA_W-1:0] active_w,
   output logic [DATA_W-1:0] w_out,
   output logic              swap_out
);

   logic [DATA_W-1:0] shadow_w;

   // Shift the shadow, copy the pre-edge shadow into active on swap, delay the swap pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_w <= '0;
         active_w <= '0;
         swap_out <= 1'b0;
      end else begin
         if (w_shift_in) shadow_w <= w_in;
         if (swap_in)    active_w <= shadow_w;
         swap_out <= swap_in;
      end
   end

   assign w_out = shadow_w;

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary MAC PE with double-buffered weights, signed/unsigned
// operands and optional saturating accumulation. One-cycle datapath.
module pe_ws_dbuf
   import pe_pkg::*;
#(
   parameter int unsigned DATA_W   = DEFAULT_DATA_W,
   parameter int unsigned ACC_W    = DEFAULT_ACC_W,
   parameter bit          SIGNED   = 1'b1,
   parameter bit          SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] a_in,
   input  logic [ACC_W-1:0]  acc_in,
   input  logic              w_shift_in,
   input  logic [DATA_W-1:0] w_in,
   input  logic              swap_in,
   input  logic              clear_flags,
   output logic              valid_out,
   output logic [DATA_W-1:0] a_out,
   output logic [ACC_W-1:0]  acc_out,
   output logic [DATA_W-1:0] w_out,
   output logic              swap_out,
   output logic              sat_flag
);

   if ((ACC_W < 2 * DATA_W) || (ACC_W > MAX_ACC_W)) begin : g_bad_width
      $error("pe_ws_dbuf: ACC_W must be >= 2*DATA_W and <= MAX_ACC_W");
   end

   localparam sat_bounds_t      BOUNDS = sat_bounds(ACC_W, SIGNED);
   localparam logic [ACC_W-1:0] SUM_HI = BOUNDS.hi[ACC_W-1:0];
   localparam logic [ACC_W-1:0] SUM_LO = BOUNDS.lo[ACC_W-1:0];
   localparam logic             SX     = SIGNED;
   localparam logic             SAT    = SATURATE;

   logic [DATA_W-1:0]   active_w;
   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] w_ext;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W:0]      prod_ext;
   logic [ACC_W:0]      acc_ext;
   logic [ACC_W:0]      sum;
   logic                overflow;
   logic [ACC_W-1:0]    acc_next;

   pe_weight_buf #(
      .DATA_W (DATA_W)
   ) u_weight_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .w_shift_in (w_shift_in),
      .w_in       (w_in),
      .swap_in    (swap_in),
      .active_w   (active_w),
      .w_out      (w_out),
      .swap_out   (swap_out)
   );

   // Multiply at 2*DATA_W with pre-extended operands (low half is exact for
   // both modes), widen to ACC_W+1, add, then detect overflow and clamp/wrap.
   always_comb begin
      a_ext    = {{DATA_W{SX & a_in[DATA_W-1]}}, a_in};
      w_ext    = {{DATA_W{SX & active_w[DATA_W-1]}}, active_w};
      prod     = a_ext * w_ext;
      prod_ext = {{(ACC_W + 1 - 2 * DATA_W){SX & prod[2*DATA_W-1]}}, prod};
      acc_ext  = {SX & acc_in[ACC_W-1], acc_in};
      sum      = prod_ext + acc_ext;
      overflow = SX ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
      acc_next = sum[ACC_W-1:0];
      // Unsigned sums can only overflow upward; signed direction is the true sign bit.
      if (SAT && overflow) acc_next = (SX && sum[ACC_W]) ? SUM_LO : SUM_HI;
   end

   // Pipeline registers and sticky flag; a set in the same cycle beats a clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out <= 1'b0;
         a_out     <= '0;
         acc_out   <= '0;
         sat_flag  <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            a_out   <= a_in;
            acc_out <= acc_next;
         end
         if (valid_in && overflow) sat_flag <= 1'b1;
         else if (clear_flags)     sat_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Bench for pe_ws_dbuf: five configurations driven by one stimulus stream,
// each compared against an integer-arithmetic reference model.
module tb_pe_ws_dbuf;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic [7:0]  a_in;
   logic [23:0] acc_in;
   logic        w_shift_in;
   logic [7:0]  w_in;
   logic        swap_in;
   logic        clear_flags;

   logic [23:0] acc0;
   logic [15:0] acc1, acc2, acc3, acc4;
   logic [7:0]  ao0, ao1, ao2, ao3, ao4;
   logic [7:0]  wo0, wo1, wo2, wo3, wo4;
   logic        vo0, vo1, vo2, vo3, vo4;
   logic        so0, so1, so2, so3, so4;
   logic        sf0, sf1, sf2, sf3, sf4;

   longint d_acc [5];
   longint d_a   [5];
   longint d_w   [5];
   longint d_v   [5];
   longint d_sw  [5];
   longint d_sat [5];

   int n_checks = 0;
   int n_fail   = 0;

   int cfg_accw [5] = '{24, 16, 16, 16, 16};
   bit cfg_sgn  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   bit cfg_sat  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   longint m_shadow [5];
   longint m_active [5];
   longint m_a      [5];
   longint m_acc    [5];
   bit     m_v      [5];
   bit     m_sw     [5];
   bit     m_sat    [5];

   always #5 clk = ~clk;

   pe_ws_dbuf #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1), .SATURATE(1'b1)) u0 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in),
      .w_shift_in(w_shift_in), .w_in(w_in), .swap_in(swap_in), .clear_flags(clear_flags),
      .valid_out(vo0), .a_out(ao0), .acc_out(acc0), .w_out(wo0), .swap_out(so0), .sat_flag(sf0));
   pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1)) u1 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_shift_in(w_shift_in), .w_in(w_in), .swap_in(swap_in), .clear_flags(clear_flags),
      .valid_out(vo1), .a_out(ao1), .acc_out(acc1), .w_out(wo1), .swap_out(so1), .sat_flag(sf1));
   pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b0)) u2 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_shift_in(w_shift_in), .w_in(w_in), .swap_in(swap_in), .clear_flags(clear_flags),
      .valid_out(vo2), .a_out(ao2), .acc_out(acc2), .w_out(wo2), .swap_out(so2), .sat_flag(sf2));
   pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b1)) u3 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_shift_in(w_shift_in), .w_in(w_in), .swap_in(swap_in), .clear_flags(clear_flags),
      .valid_out(vo3), .a_out(ao3), .acc_out(acc3), .w_out(wo3), .swap_out(so3), .sat_flag(sf3));
   pe_ws_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b0)) u4 (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .a_in(a_in), .acc_in(acc_in[15:0]),
      .w_shift_in(w_shift_in), .w_in(w_in), .swap_in(swap_in), .clear_flags(clear_flags),
      .valid_out(vo4), .a_out(ao4), .acc_out(acc4), .w_out(wo4), .swap_out(so4), .sat_flag(sf4));

   // Gather the five instances' outputs into indexable arrays.
   always_comb begin
      d_acc[0] = longint'(acc0); d_acc[1] = longint'(acc1); d_acc[2] = longint'(acc2);
      d_acc[3] = longint'(acc3); d_acc[4] = longint'(acc4);
      d_a[0] = longint'(ao0); d_a[1] = longint'(ao1); d_a[2] = longint'(ao2);
      d_a[3] = longint'(ao3); d_a[4] = longint'(ao4);
      d_w[0] = longint'(wo0); d_w[1] = longint'(wo1); d_w[2] = longint'(wo2);
      d_w[3] = longint'(wo3); d_w[4] = longint'(wo4);
      d_v[0] = longint'(vo0); d_v[1] = longint'(vo1); d_v[2] = longint'(vo2);
      d_v[3] = longint'(vo3); d_v[4] = longint'(vo4);
      d_sw[0] = longint'(so0); d_sw[1] = longint'(so1); d_sw[2] = longint'(so2);
      d_sw[3] = longint'(so3); d_sw[4] = longint'(so4);
      d_sat[0] = longint'(sf0); d_sat[1] = longint'(sf1); d_sat[2] = longint'(sf2);
      d_sat[3] = longint'(sf3); d_sat[4] = longint'(sf4);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Interpret the low 'width' bits of raw as a signed or unsigned integer.
   function automatic longint as_val(input longint raw, input int width, input bit sg);
      longint one, v;
      one = 1;
      v = raw & ((one <<< width) - 1);
      if (sg && v[width-1]) v = v - (one <<< width);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         m_shadow[i] = 0; m_active[i] = 0; m_a[i] = 0; m_acc[i] = 0;
         m_v[i] = 1'b0; m_sw[i] = 1'b0; m_sat[i] = 1'b0;
      end
   endtask

   // Advance the reference by one clock using the inputs present at the edge.
   task automatic model_step();
      for (int i = 0; i < 5; i++) begin
         longint old_shadow, s, lo, hi, one;
         int     aw;
         bit     sg, oor;
         one = 1;
         aw  = cfg_accw[i];
         sg  = cfg_sgn[i];
         oor = 1'b0;
         old_shadow = m_shadow[i];
         if (valid_in) begin
            s  = as_val(a_in, 8, sg) * as_val(m_active[i], 8, sg) + as_val(acc_in, aw, sg);
            hi = sg ? (one <<< (aw - 1)) - 1 : (one <<< aw) - 1;
            lo = sg ? -(one <<< (aw - 1)) : 0;
            oor = (s < lo) || (s > hi);
            if (oor && cfg_sat[i]) s = (s < lo) ? lo : hi;
            m_acc[i] = s & ((one <<< aw) - 1);
            m_a[i]   = a_in;
            m_v[i]   = 1'b1;
         end else begin
            m_v[i] = 1'b0;
         end
         if (valid_in && oor) m_sat[i] = 1'b1;
         else if (clear_flags) m_sat[i] = 1'b0;
         m_sw[i] = swap_in;
         if (swap_in)    m_active[i] = old_shadow;
         if (w_shift_in) m_shadow[i] = w_in;
      end
   endtask

   task automatic compare_all(input string ph);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("%s.u%0d.valid_out", ph, i), d_v[i],   longint'(m_v[i]));
         check($sformatf("%s.u%0d.a_out",     ph, i), d_a[i],   m_a[i]);
         check($sformatf("%s.u%0d.acc_out",   ph, i), d_acc[i], m_acc[i]);
         check($sformatf("%s.u%0d.w_out",     ph, i), d_w[i],   m_shadow[i]);
         check($sformatf("%s.u%0d.swap_out",  ph, i), d_sw[i],  longint'(m_sw[i]));
         check($sformatf("%s.u%0d.sat_flag",  ph, i), d_sat[i], longint'(m_sat[i]));
      end
   endtask

   task automatic drive(input bit v, input logic [7:0] a, input logic [23:0] acc,
                        input bit sh, input logic [7:0] w, input bit sw, input bit clr);
      valid_in = v; a_in = a; acc_in = acc;
      w_shift_in = sh; w_in = w; swap_in = sw; clear_flags = clr;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic cycle(input string ph);
      @(posedge clk);
      model_step();
      #1;
      compare_all(ph);
   endtask

   // Assert reset in the middle of a busy cycle, then release with valid low.
   task automatic mid_reset(input string ph);
      drive(1'b1, 8'h55, 24'h001234, 1'b1, 8'h33, 1'b1, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all({ph, ".async"});
      @(posedge clk);
      #1;
      compare_all({ph, ".held"});
      idle();
      reset_n = 1'b1;
      cycle({ph, ".release"});
      cycle({ph, ".release2"});
   endtask

   function automatic logic [23:0] pick_acc();
      case ($urandom_range(0, 6))
         0:       return 24'h007FFF;
         1:       return 24'hFF8000;
         2:       return 24'h7FFFFF;
         3:       return 24'h800000;
         4:       return 24'h00FFFF;
         5:       return 24'h000000;
         default: return 24'($urandom);
      endcase
   endfunction

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 5))
         0:       return 8'h7F;
         1:       return 8'h80;
         2:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      reset_n = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      reset_n = 1'b1;
      cycle("post_reset");

      // Basic MAC: weight 3, activation -4, partial sum 100.
      drive(1'b0, 8'h00, 24'd0, 1'b1, 8'd3, 1'b0, 1'b0); cycle("basic.shift");
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0); cycle("basic.swap");
      check("basic.swap_pulse", d_sw[0], 1);
      drive(1'b1, 8'hFC, 24'd100, 1'b0, 8'd0, 1'b0, 1'b0); cycle("basic.mac");
      check("basic.acc_88", d_acc[0], 88);
      check("basic.a_fc", d_a[0], 'hFC);
      check("basic.swap_one_cycle", d_sw[0], 0);
      idle(); cycle("basic.idle");

      // Swap, shift and MAC in the same cycle.
      drive(1'b0, 8'h00, 24'd0, 1'b1, 8'd2, 1'b0, 1'b0); cycle("coll.sh2");
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0); cycle("coll.sw2");
      drive(1'b0, 8'h00, 24'd0, 1'b1, 8'd5, 1'b0, 1'b0); cycle("coll.sh5");
      drive(1'b1, 8'd10, 24'd0, 1'b1, 8'd7, 1'b1, 1'b0); cycle("coll.all");
      check("coll.acc_20", d_acc[0], 20);
      check("coll.w_out_7", d_w[0], 7);
      drive(1'b1, 8'd10, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0); cycle("coll.next");
      check("coll.acc_50", d_acc[0], 50);

      // Saturation at the positive and negative limits.
      drive(1'b0, 8'h00, 24'd0, 1'b1, 8'd127, 1'b0, 1'b1); cycle("sat.sh127");
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0); cycle("sat.sw");
      drive(1'b1, 8'd127, 24'h007FFF, 1'b0, 8'd0, 1'b0, 1'b0); cycle("sat.pos");
      check("sat.pos_clamp", d_acc[1], 32767);
      check("sat.pos_flag", d_sat[1], 1);
      check("sat.wrap_flag", d_sat[2], 1);
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b0, 1'b1); cycle("sat.clr");
      check("sat.clr_alone", d_sat[1], 0);
      drive(1'b0, 8'h00, 24'd0, 1'b1, 8'h80, 1'b0, 1'b0); cycle("sat.sh128");
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0); cycle("sat.sw2");
      drive(1'b1, 8'd127, 24'hFF8000, 1'b0, 8'd0, 1'b0, 1'b1); cycle("sat.neg");
      check("sat.neg_clamp", d_acc[1], 'h8000);
      check("sat.set_beats_clear", d_sat[1], 1);
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b0, 1'b1); cycle("sat.clr2");
      check("sat.clr_alone2", d_sat[1], 0);

      // Unsigned mode.
      drive(1'b0, 8'h00, 24'd0, 1'b1, 8'd255, 1'b0, 1'b0); cycle("uns.sh");
      drive(1'b0, 8'h00, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0); cycle("uns.sw");
      drive(1'b1, 8'd255, 24'd0, 1'b0, 8'd0, 1'b0, 1'b0); cycle("uns.mac");
      check("uns.acc_65025", d_acc[3], 65025);
      check("uns.no_flag", d_sat[3], 0);
      drive(1'b1, 8'd255, 24'd1000, 1'b0, 8'd0, 1'b0, 1'b0); cycle("uns.sat");
      check("uns.acc_65535", d_acc[3], 65535);
      check("uns.flag", d_sat[3], 1);

      // Hold with valid low.
      idle();
      repeat (3) cycle("hold");

      mid_reset("reset_mid");

      // Randomised traffic with one more reset partway through.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) mid_reset("reset_rand");
         drive($urandom_range(0, 3) != 0, pick_byte(), pick_acc(),
               $urandom_range(0, 2) == 0, pick_byte(),
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
